fsm_out_tracker: RTL
====================

Name: fsm_out_tracker

Overview:
Parametrised, synthesizable multi-channel FSM state-change tracker for the fsm_out HDL side.
- Watches NUM_CH FSM state buses and detects every enabled state transition.
- Stamps each transition with a free-running timestamp and queues {channel, previous, current, timestamp} records in a FIFO.
- Records drain through a valid/ready port to the BFM or a downstream checker.
- Adds what the single-channel, unbuffered scheme lacks: channel count, per-channel masking, buffering, overflow accounting.

Parameters:
NUM_CH, 4, number of monitored FSM channels (>=1)
STATE_W, 4, width of each state bus
DEPTH, 8, event FIFO depth (power of 2, >=2)
TS_W, 16, timestamp width

Ports:
clk  in  1  single clock, rising edge
rst  in  1  reset, asynchronous, active-high
en  in  1  capture enable
ch_mask  in  NUM_CH  per-channel event enable
state_in  in  NUM_CH*STATE_W  channel c at bits [c*STATE_W +: STATE_W]
clr_overflow  in  1  clears overflow and drop_cnt
evt_valid  out  1  FIFO head valid
evt_ready  in  1  consumer accepts head
evt_chan  out  max(1,$clog2(NUM_CH))  channel index of head
evt_prev  out  STATE_W  state before transition
evt_curr  out  STATE_W  state after transition
evt_ts  out  TS_W  timestamp of the sampling edge
evt_count  out  $clog2(DEPTH+1)  FIFO occupancy
overflow  out  1  sticky drop flag
drop_cnt  out  16  dropped-event count, saturating

Behaviour:
- Reset: the clock is clk; reset is rst, asynchronous and active-high. All outputs 0, FIFO empty, pending slots clear, armed=0, RR pointer=0, ts=0. Reset mid-operation discards all queued and pending events immediately.
- Timestamp: ts increments each clk while en=1 and wraps 2^TS_W-1 -> 0. Held while en=0.
- Arming:
  - en=0 clears armed.
  - The first edge with en=1 loads prev[c]=state_in[c] for all channels, sets armed, and generates no event.
- Tracking: prev[c] tracks state_in[c] every edge regardless of en or ch_mask.
- Detection: at edge k, if armed & en & ch_mask[c] & state_in[c]!=prev[c], a pending record {c, prev[c], state_in[c], ts} is formed. ts is the value before this edge's increment.
- Pending slots: one per channel.
  - Empty slot: the record is stored.
  - Slot occupied and not granted this cycle: the new record is dropped; overflow<=1; drop_cnt+1, saturating at 16'hFFFF.
  - Slot granted in the same cycle: the old record moves to the FIFO and the new record takes the slot; no drop.
- Arbitration:
  - Round-robin over pending slots, starting at the RR pointer.
  - At most one grant per cycle.
  - No grant when the FIFO is full. The full check uses pre-pop occupancy and does not depend on evt_ready.
  - After a grant, pointer = (granted+1) mod NUM_CH.
- Latency: change sampled at edge k -> pending after k -> FIFO write at k+1 (if granted) -> evt_valid=1 after edge k+1. Minimum 2 cycles.
- Output: show-ahead FIFO. evt_* reflect the head while evt_valid=1.
  - Pop on evt_valid & evt_ready.
  - Simultaneous push and pop: occupancy is unchanged.
  - evt_* hold while valid & !ready.
  - Head fields are don't-care when evt_valid=0; the bench must ignore them.
- Drain: draining of pending slots and the FIFO continues when en=0 or ch_mask=0.
- Clearing: clr_overflow clears overflow and drop_cnt. A drop in the same cycle wins: overflow=1, drop_cnt=1.
- Multiple simultaneous changes on different channels are all captured as pending records, each with the same ts.

Decomposition:
- fsm_out_tracker_pkg:
  - typedef struct packed fsm_evt_t {chan, prev, curr, ts};
  - CH_W helper function;
  - drop counter width constant DROP_W=16.
- Sub-module fsm_out_evt_fifo: synchronous show-ahead FIFO with parameters WIDTH and DEPTH, push/pop/full/empty/count, async active-high reset on rst.

Test Plan:
- Reset, en=1, ch_mask=4'hF, all states 0. Ch1 0->3 at ts=5 -> after 2 cycles evt_valid=1 with chan=1, prev=0, curr=3, ts=5.
- All 4 channels change on one edge (ts=10), evt_ready=1 -> 4 events in order ch0,1,2,3, all ts=10. RR pointer then 0.
- evt_ready=0, 10 events over time with DEPTH=8 -> evt_count saturates at 8. Later events stay pending. Further same-channel changes drop: overflow=1, drop_cnt counts them. Release ready -> 8 FIFO events plus the pending ones drain, no duplicates.
- ch_mask=4'b1110, ch0 toggles -> no events. Set mask bit, no state change -> no event, since prev tracked.
- en low for 3 cycles with ch2 changing, then en high -> no event on the arming edge, ts resumed from its held value. Next change is reported with correct prev.
- Assert rst with 5 events queued -> evt_valid=0, evt_count=0, overflow=0 immediately (async). Drop and clr_overflow in the same cycle -> overflow=1, drop_cnt=1.

Source files
------------

// File: rtl/fsm_out_tracker_pkg.sv
// fsm_out_tracker_pkg: shared types and helpers for the FSM state-change tracker.
//   DROP_W      - width of the saturating dropped-event counter
//   ch_w()      - channel-index width, never less than one bit
//   fsm_evt_t   - event record layout {chan, prev, curr, ts} for the default
//                 4-channel / 4-bit state / 16-bit timestamp configuration
package fsm_out_tracker_pkg;

  localparam int unsigned DROP_W = 16;

  function automatic int unsigned ch_w(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  localparam int unsigned DEF_NUM_CH  = 4;
  localparam int unsigned DEF_STATE_W = 4;
  localparam int unsigned DEF_TS_W    = 16;

  typedef struct packed {
    logic [ch_w(DEF_NUM_CH)-1:0] chan;
    logic [DEF_STATE_W-1:0]      prev;
    logic [DEF_STATE_W-1:0]      curr;
    logic [DEF_TS_W-1:0]         ts;
  } fsm_evt_t;

endpackage

// File: rtl/fsm_out_tracker_if.sv
// fsm_out_tracker_if: valid/ready event port of the tracker.
//   master - tracker side: drives evt_valid and head fields, samples evt_ready
//   slave  - consumer side: samples head fields, drives evt_ready
interface fsm_out_tracker_if
  import fsm_out_tracker_pkg::*;
#(
  parameter int unsigned NUM_CH  = 4,
  parameter int unsigned STATE_W = 4,
  parameter int unsigned DEPTH   = 8,
  parameter int unsigned TS_W    = 16
);
  localparam int unsigned CH_W  = ch_w(NUM_CH);
  localparam int unsigned CNT_W = $clog2(DEPTH + 1);

  logic               evt_valid;
  logic               evt_ready;
  logic [CH_W-1:0]    evt_chan;
  logic [STATE_W-1:0] evt_prev;
  logic [STATE_W-1:0] evt_curr;
  logic [TS_W-1:0]    evt_ts;
  logic [CNT_W-1:0]   evt_count;

  modport master (
    output evt_valid, evt_chan, evt_prev, evt_curr, evt_ts, evt_count,
    input  evt_ready
  );

  modport slave (
    input  evt_valid, evt_chan, evt_prev, evt_curr, evt_ts, evt_count,
    output evt_ready
  );
endinterface

// File: rtl/fsm_out_evt_fifo.sv
// fsm_out_evt_fifo: synchronous show-ahead FIFO.
//   clk, rst      - clock, asynchronous active-high reset
//   push, wdata   - write request (ignored when full)
//   pop, rdata    - read request (ignored when empty); rdata is the current head
//   full, empty   - occupancy flags
//   count         - occupancy, 0..DEPTH
module fsm_out_evt_fifo
  import fsm_out_tracker_pkg::*;
#(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned DEPTH = 8
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       push,
  input  logic [WIDTH-1:0]           wdata,
  input  logic                       pop,
  output logic [WIDTH-1:0]           rdata,
  output logic                       full,
  output logic                       empty,
  output logic [$clog2(DEPTH+1)-1:0] count
);
  localparam int unsigned AW    = $clog2(DEPTH);
  localparam int unsigned CNT_W = $clog2(DEPTH + 1);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             do_push, do_pop;

  assign full    = (count_q == CNT_W'(DEPTH));
  assign empty   = (count_q == '0);
  assign count   = count_q;
  assign rdata   = mem_q[rd_ptr_q];
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (do_push) wr_ptr_d = wr_ptr_q + AW'(1);
    if (do_pop)  rd_ptr_d = rd_ptr_q + AW'(1);
    case ({do_push, do_pop})
      2'b10:   count_d = count_q + CNT_W'(1);
      2'b01:   count_d = count_q - CNT_W'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= wdata;
  end
endmodule

// File: rtl/fsm_out_tracker.sv
// fsm_out_tracker: multi-channel FSM state-change tracker.
//   clk, rst     - clock, asynchronous active-high reset
//   en           - capture enable (also gates the timestamp)
//   ch_mask      - per-channel event enable
//   state_in     - NUM_CH packed state buses, channel c at [c*STATE_W +: STATE_W]
//   clr_overflow - clears overflow and drop_cnt (a same-cycle drop still counts)
//   evt          - valid/ready event port {chan, prev, curr, ts} plus occupancy
//   overflow     - sticky flag, set when a record is dropped
//   drop_cnt     - saturating count of dropped records
module fsm_out_tracker
  import fsm_out_tracker_pkg::*;
#(
  parameter int unsigned NUM_CH  = 4,
  parameter int unsigned STATE_W = 4,
  parameter int unsigned DEPTH   = 8,
  parameter int unsigned TS_W    = 16
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        en,
  input  logic [NUM_CH-1:0]           ch_mask,
  input  logic [NUM_CH*STATE_W-1:0]   state_in,
  input  logic                        clr_overflow,
  fsm_out_tracker_if.master           evt,
  output logic                        overflow,
  output logic [DROP_W-1:0]           drop_cnt
);
  localparam int unsigned CH_W  = ch_w(NUM_CH);
  localparam int unsigned CNT_W = $clog2(DEPTH + 1);

  typedef struct packed {
    logic [CH_W-1:0]    chan;
    logic [STATE_W-1:0] prev;
    logic [STATE_W-1:0] curr;
    logic [TS_W-1:0]    ts;
  } evt_t;

  logic [TS_W-1:0]    ts_q, ts_d;
  logic               armed_q, armed_d;
  logic [STATE_W-1:0] prev_q [NUM_CH];
  logic [STATE_W-1:0] prev_d [NUM_CH];
  logic [NUM_CH-1:0]  pend_vld_q, pend_vld_d;
  evt_t               pend_q [NUM_CH];
  evt_t               pend_d [NUM_CH];
  logic [CH_W-1:0]    rr_q, rr_d;
  logic               overflow_q, overflow_d;
  logic [DROP_W-1:0]  drop_q, drop_d;

  logic               gnt_vld;
  logic [CH_W-1:0]    gnt_idx;
  logic [CH_W-1:0]    rr_idx;
  logic [STATE_W-1:0] cur;
  int unsigned        n_drop;
  logic [DROP_W:0]    drop_sum;

  evt_t               fifo_head;
  logic               fifo_full, fifo_empty, fifo_pop;
  logic [CNT_W-1:0]   fifo_count;

  // Round-robin grant; blocked on pre-pop fullness so it never depends on evt_ready.
  always_comb begin
    gnt_vld = 1'b0;
    gnt_idx = '0;
    rr_idx  = '0;
    if (!fifo_full) begin
      for (int unsigned i = 0; i < NUM_CH; i++) begin
        rr_idx = CH_W'((32'(rr_q) + i) % NUM_CH);
        if (!gnt_vld && pend_vld_q[rr_idx]) begin
          gnt_vld = 1'b1;
          gnt_idx = rr_idx;
        end
      end
    end
  end

  always_comb begin
    ts_d       = en ? ts_q + TS_W'(1) : ts_q;
    armed_d    = en;
    pend_vld_d = pend_vld_q;
    n_drop     = 0;
    cur        = '0;
    for (int unsigned c = 0; c < NUM_CH; c++) begin
      cur       = state_in[c*STATE_W +: STATE_W];
      prev_d[c] = cur;
      pend_d[c] = pend_q[c];
      // Clearing the granted slot first lets a same-cycle record refill it without a drop.
      if (gnt_vld && gnt_idx == CH_W'(c)) pend_vld_d[c] = 1'b0;
      if (armed_q && en && ch_mask[c] && cur != prev_q[c]) begin
        if (pend_vld_d[c]) begin
          n_drop = n_drop + 1;
        end else begin
          pend_vld_d[c] = 1'b1;
          pend_d[c]     = '{chan: CH_W'(c), prev: prev_q[c], curr: cur, ts: ts_q};
        end
      end
    end

    rr_d = rr_q;
    if (gnt_vld) rr_d = (32'(gnt_idx) == NUM_CH - 1) ? '0 : gnt_idx + CH_W'(1);

    // Clear applies before this cycle's drops are added, so a simultaneous drop survives.
    drop_sum   = {1'b0, (clr_overflow ? '0 : drop_q)} + (DROP_W+1)'(n_drop);
    drop_d     = drop_sum[DROP_W] ? '1 : drop_sum[DROP_W-1:0];
    overflow_d = (clr_overflow ? 1'b0 : overflow_q) | (n_drop != 0);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ts_q       <= '0;
      armed_q    <= 1'b0;
      pend_vld_q <= '0;
      rr_q       <= '0;
      overflow_q <= 1'b0;
      drop_q     <= '0;
      for (int unsigned c = 0; c < NUM_CH; c++) begin
        prev_q[c] <= '0;
        pend_q[c] <= '0;
      end
    end else begin
      ts_q       <= ts_d;
      armed_q    <= armed_d;
      pend_vld_q <= pend_vld_d;
      rr_q       <= rr_d;
      overflow_q <= overflow_d;
      drop_q     <= drop_d;
      prev_q     <= prev_d;
      pend_q     <= pend_d;
    end
  end

  assign fifo_pop = !fifo_empty && evt.evt_ready;

  fsm_out_evt_fifo #(
    .WIDTH ($bits(evt_t)),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (gnt_vld),
    .wdata (pend_q[gnt_idx]),
    .pop   (fifo_pop),
    .rdata (fifo_head),
    .full  (fifo_full),
    .empty (fifo_empty),
    .count (fifo_count)
  );

  // Head fields are forced to zero while empty so every output reads 0 out of reset.
  assign evt.evt_valid = !fifo_empty;
  assign evt.evt_chan  = fifo_empty ? '0 : fifo_head.chan;
  assign evt.evt_prev  = fifo_empty ? '0 : fifo_head.prev;
  assign evt.evt_curr  = fifo_empty ? '0 : fifo_head.curr;
  assign evt.evt_ts    = fifo_empty ? '0 : fifo_head.ts;
  assign evt.evt_count = fifo_count;
  assign overflow      = overflow_q;
  assign drop_cnt      = drop_q;
endmodule
